// File: rtl/adder_sum_accumulator.sv
// Accumulates N_SAMPLES unsigned {Co,S} adder results into a saturating total.
// Each finished total is handed downstream with a valid/ready handshake.
module adder_sum_accumulator #(
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned N_SAMPLES = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      S,
    input  logic             Co,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;
    logic [SUM_W-1:0] sum;

    // One spare bit catches the carry out of the accumulator.
    assign sum = {1'b0, acc_out} + SUM_W'({Co, S});

    // Status outputs are decodes of the state flop; in_ready is also held low during reset.
    assign in_ready  = (state == ACCUM) && !rst;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            acc_out    <= '0;
            acc_ovf    <= 1'b0;
            sample_cnt <= '0;
        end else begin
            state      <= state_next;
            acc_out    <= acc_next;
            acc_ovf    <= ovf_next;
            sample_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc_out;
        ovf_next   = acc_ovf;
        cnt_next   = sample_cnt;

        if (clear) begin
            // Abort wins over any simultaneous accept or handoff.
            state_next = ACCUM;
            acc_next   = '0;
            ovf_next   = 1'b0;
            cnt_next   = '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                        ovf_next = acc_ovf | sum[ACC_W];
                        cnt_next = sample_cnt + CNT_W'(1);
                        if (sample_cnt == LAST_CNT) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = ACCUM;
                        acc_next   = '0;
                        ovf_next   = 1'b0;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

endmodule
